// File: rtl/iq_decim_pkg.sv
// Shared definitions for the I/Q decimator: default geometry, width helpers
// and the counter types used by the top level.
package iq_decim_pkg;

    // Default geometry; the top-level parameters default to these values and
    // the counter typedefs below are sized from them.
    localparam int IQD_DATA_WIDTH     = 16;
    localparam int IQD_MAX_LOG2_DECIM = 4;
    localparam int IQD_PKT_LEN_WIDTH  = 16;

    // Accumulator width: enough headroom to sum 2^max_log2_decim samples.
    function automatic int ACC_W(input int data_width, input int max_log2_decim);
        return data_width + max_log2_decim;
    endfunction

    // Width of the decimation exponent k (0..max_log2_decim).
    function automatic int K_W(input int max_log2_decim);
        return (max_log2_decim < 1) ? 1 : $clog2(max_log2_decim + 1);
    endfunction

    // Position of the next accepted sample inside its group (0..N-1).
    typedef logic [IQD_MAX_LOG2_DECIM-1:0] phase_t;

    // Output samples emitted so far in the current output packet.
    typedef logic [IQD_PKT_LEN_WIDTH-1:0] pkt_cnt_t;

endpackage

// File: rtl/iq_decim_acc.sv
// One channel of the decimator. With IQ_DECIM_AVG_EN defined it sums the
// group and returns floor(sum / 2^k); otherwise it returns the current sample,
// so the value presented on the group's closing sample is the group's last.
module iq_decim_acc
    import iq_decim_pkg::*;
#(
    parameter int DATA_WIDTH     = IQD_DATA_WIDTH,
    parameter int MAX_LOG2_DECIM = IQD_MAX_LOG2_DECIM
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 clear,
    input  logic                                 accept,
    input  logic                                 group_start,
    input  logic [K_W(MAX_LOG2_DECIM)-1:0]       k_cur,
    input  logic signed [DATA_WIDTH-1:0]         in_sample,
    output logic signed [DATA_WIDTH-1:0]         result
);

`ifdef IQ_DECIM_AVG_EN
    localparam int AW = ACC_W(DATA_WIDTH, MAX_LOG2_DECIM);

    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] acc_base;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] shifted;

    // Running sum including the current sample; a new group ignores stale state.
    always_comb begin
        acc_base = group_start ? {AW{1'b0}} : acc_q;
        sum      = acc_base + {{MAX_LOG2_DECIM{in_sample[DATA_WIDTH-1]}}, in_sample};
        shifted  = sum >>> k_cur;
        result   = shifted[DATA_WIDTH-1:0];
        acc_d    = acc_q;
        if (accept) begin
            acc_d = sum;
        end
        if (clear) begin
            acc_d = '0;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    logic unused_avg_off;

    // Keep-last mode: the closing sample is the group's output.
    always_comb begin
        result = in_sample;
    end

    assign unused_avg_off = ^{clk, reset_n, clear, accept, group_start, k_cur};
`endif

endmodule

// File: rtl/iq_decim_stream.sv
// Decimates an I/Q AXI-stream by 2^k and regenerates tlast on a programmable
// output packet length, with a single registered output stage.
// Optional feature macro: IQ_DECIM_AVG_EN (group averaging instead of keep-last).
//
// Handshake: a beat transfers on any rising edge where valid && ready are both
// high. in_tready = !out_tvalid || out_tready, so the output register is
// always free (or being drained) when an emitting sample is accepted; output
// data and tlast hold steady while out_tvalid && !out_tready.
module iq_decim_stream
    import iq_decim_pkg::*;
#(
    parameter int DATA_WIDTH     = IQD_DATA_WIDTH,
    parameter int MAX_LOG2_DECIM = IQD_MAX_LOG2_DECIM,
    parameter int PKT_LEN_WIDTH  = IQD_PKT_LEN_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              clear,
    input  logic [K_W(MAX_LOG2_DECIM)-1:0]    decim_log2,
    input  logic [PKT_LEN_WIDTH-1:0]          pkt_len,
    input  logic                              in_tvalid,
    input  logic                              in_tlast,
    output logic                              in_tready,
    input  logic signed [DATA_WIDTH-1:0]      in_i,
    input  logic signed [DATA_WIDTH-1:0]      in_q,
    output logic                              out_tvalid,
    output logic                              out_tlast,
    input  logic                              out_tready,
    output logic signed [DATA_WIDTH-1:0]      out_i,
    output logic signed [DATA_WIDTH-1:0]      out_q
);

    localparam int KW = K_W(MAX_LOG2_DECIM);
    localparam int NW = MAX_LOG2_DECIM + 1;

    phase_t                         phase_q, phase_d;
    pkt_cnt_t                       pkt_cnt_q, pkt_cnt_d;
    logic [KW-1:0]                  k_lat_q, k_lat_d;
    logic [PKT_LEN_WIDTH-1:0]       pkt_len_lat_q, pkt_len_lat_d;
    logic                           out_tvalid_q, out_tvalid_d;
    logic                           out_tlast_q, out_tlast_d;
    logic signed [DATA_WIDTH-1:0]   out_i_q, out_i_d;
    logic signed [DATA_WIDTH-1:0]   out_q_q, out_q_d;

    logic                           accept;
    logic                           group_start;
    logic                           emit;
    logic                           hit_len;
    logic [KW-1:0]                  k_sat;
    logic [KW-1:0]                  k_eff;
    logic [PKT_LEN_WIDTH-1:0]       pkt_len_eff;
    logic [NW-1:0]                  n_eff;
    phase_t                         phase_last;
    logic signed [DATA_WIDTH-1:0]   res_i, res_q;

    // Configuration is sampled only on the first sample of a group; mid-group
    // changes are deferred so a group never mixes two decimation factors.
    always_comb begin
        in_tready   = !out_tvalid_q || out_tready;
        accept      = in_tvalid && in_tready;
        group_start = (phase_q == '0);
        k_sat       = (decim_log2 > KW'(MAX_LOG2_DECIM)) ? KW'(MAX_LOG2_DECIM) : decim_log2;
        k_eff       = group_start ? k_sat : k_lat_q;
        pkt_len_eff = group_start ? pkt_len : pkt_len_lat_q;
        n_eff       = NW'(1) << k_eff;
        phase_last  = phase_t'(n_eff - NW'(1));
        emit        = accept && ((phase_q == phase_last) || in_tlast);
        hit_len     = (pkt_len_eff != '0) && (pkt_cnt_q >= (pkt_len_eff - PKT_LEN_WIDTH'(1)));
    end

    iq_decim_acc #(
        .DATA_WIDTH     (DATA_WIDTH),
        .MAX_LOG2_DECIM (MAX_LOG2_DECIM)
    ) u_acc_i (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .accept      (accept),
        .group_start (group_start),
        .k_cur       (k_eff),
        .in_sample   (in_i),
        .result      (res_i)
    );

    iq_decim_acc #(
        .DATA_WIDTH     (DATA_WIDTH),
        .MAX_LOG2_DECIM (MAX_LOG2_DECIM)
    ) u_acc_q (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .accept      (accept),
        .group_start (group_start),
        .k_cur       (k_eff),
        .in_sample   (in_q),
        .result      (res_q)
    );

    // Next state: phase/packet counters, config latch and output register.
    always_comb begin
        phase_d       = phase_q;
        pkt_cnt_d     = pkt_cnt_q;
        k_lat_d       = k_lat_q;
        pkt_len_lat_d = pkt_len_lat_q;
        out_tvalid_d  = out_tvalid_q;
        out_tlast_d   = out_tlast_q;
        out_i_d       = out_i_q;
        out_q_d       = out_q_q;

        if (accept) begin
            if (group_start) begin
                k_lat_d       = k_sat;
                pkt_len_lat_d = pkt_len;
            end
            phase_d = emit ? '0 : phase_q + phase_t'(1);
        end

        if (out_tvalid_q && out_tready) begin
            out_tvalid_d = 1'b0;
        end

        if (emit) begin
            out_tvalid_d = 1'b1;
            out_i_d      = res_i;
            out_q_d      = res_q;
            if (in_tlast) begin
                // An input burst end closes the output packet as well.
                out_tlast_d = 1'b1;
                pkt_cnt_d   = '0;
            end else if (pkt_len_eff != '0) begin
                out_tlast_d = hit_len;
                pkt_cnt_d   = hit_len ? '0 : pkt_cnt_q + pkt_cnt_t'(1);
            end else begin
                out_tlast_d = 1'b0;
                pkt_cnt_d   = '0;
            end
        end

        // Flush drops any in-flight output and beats a same-cycle input.
        if (clear) begin
            phase_d      = '0;
            pkt_cnt_d    = '0;
            out_tvalid_d = 1'b0;
            out_tlast_d  = 1'b0;
            out_i_d      = '0;
            out_q_d      = '0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q       <= '0;
            pkt_cnt_q     <= '0;
            k_lat_q       <= '0;
            pkt_len_lat_q <= '0;
            out_tvalid_q  <= 1'b0;
            out_tlast_q   <= 1'b0;
            out_i_q       <= '0;
            out_q_q       <= '0;
        end else begin
            phase_q       <= phase_d;
            pkt_cnt_q     <= pkt_cnt_d;
            k_lat_q       <= k_lat_d;
            pkt_len_lat_q <= pkt_len_lat_d;
            out_tvalid_q  <= out_tvalid_d;
            out_tlast_q   <= out_tlast_d;
            out_i_q       <= out_i_d;
            out_q_q       <= out_q_d;
        end
    end

    assign out_tvalid = out_tvalid_q;
    assign out_tlast  = out_tlast_q;
    assign out_i      = out_i_q;
    assign out_q      = out_q_q;

endmodule

// File: tb/tb_iq_decim_stream.sv
// Bench for iq_decim_stream: directed vector table, hand-written corner
// sequences and randomized traffic scored against a group-level model.
module tb_iq_decim_stream;
    import iq_decim_pkg::*;

    localparam int DW = 16;
    localparam int PW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic                  clear;
    logic [2:0]            decim_log2;
    logic [PW-1:0]         pkt_len;
    logic                  in_tvalid, in_tlast, in_tready;
    logic signed [DW-1:0]  in_i, in_q;
    logic                  out_tvalid, out_tlast, out_tready;
    logic signed [DW-1:0]  out_i, out_q;

    iq_decim_stream #(
        .DATA_WIDTH     (DW),
        .MAX_LOG2_DECIM (4),
        .PKT_LEN_WIDTH  (PW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .decim_log2 (decim_log2),
        .pkt_len    (pkt_len),
        .in_tvalid  (in_tvalid),
        .in_tlast   (in_tlast),
        .in_tready  (in_tready),
        .in_i       (in_i),
        .in_q       (in_q),
        .out_tvalid (out_tvalid),
        .out_tlast  (out_tlast),
        .out_tready (out_tready),
        .out_i      (out_i),
        .out_q      (out_q)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Groups are collected as lists; a group closes after 2^k samples or on
    // input tlast, and produces either its last sample or floor(mean).
    logic [2*DW:0] exp_q[$];
    int grp_i[$];
    int grp_q[$];
    int grp_k;
    int grp_pl;
    int pc;

    function automatic int floor_div(input int s, input int n);
        int r;
        r = s / n;
        if ((s % n != 0) && (s < 0)) r = r - 1;
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        grp_i.delete();
        grp_q.delete();
        pc = 0;
    endtask

    task automatic model_accept(input int si, input int sq, input bit last);
        int oi, oq, si_sum, sq_sum, n;
        bit ol;
        logic [DW-1:0] oi_v, oq_v;
        if (grp_i.size() == 0) begin
            grp_k  = (int'(decim_log2) > 4) ? 4 : int'(decim_log2);
            grp_pl = int'(pkt_len);
        end
        grp_i.push_back(si);
        grp_q.push_back(sq);
        n = 1 << grp_k;
        if (grp_i.size() == n || last) begin
`ifdef IQ_DECIM_AVG_EN
            si_sum = 0;
            sq_sum = 0;
            foreach (grp_i[j]) begin
                si_sum += grp_i[j];
                sq_sum += grp_q[j];
            end
            oi = floor_div(si_sum, n);
            oq = floor_div(sq_sum, n);
`else
            si_sum = 0;
            sq_sum = 0;
            oi = grp_i[grp_i.size()-1];
            oq = grp_q[grp_q.size()-1];
`endif
            if (last) begin
                ol = 1'b1;
                pc = 0;
            end else if (grp_pl != 0) begin
                ol = (pc >= grp_pl - 1);
                pc = ol ? 0 : pc + 1;
            end else begin
                ol = 1'b0;
                pc = 0;
            end
            oi_v = oi[DW-1:0];
            oq_v = oq[DW-1:0];
            exp_q.push_back({ol, oi_v, oq_v});
            grp_i.delete();
            grp_q.delete();
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    bit            hold_chk = 1'b0;
    logic [2*DW:0] hold_val;
    logic [2*DW:0] e;

    always @(negedge clk) begin
        if (!reset_n) begin
            model_reset();
            hold_chk = 1'b0;
        end else begin
            check("in_tready", int'(in_tready), int'(!out_tvalid || out_tready));
            if (hold_chk) begin
                check("hold_valid", int'(out_tvalid), 1);
                check("hold_i", int'(out_i), int'($signed(hold_val[2*DW-1:DW])));
                check("hold_q", int'(out_q), int'($signed(hold_val[DW-1:0])));
                check("hold_last", int'(out_tlast), int'(hold_val[2*DW]));
            end
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_i", int'(out_i), int'($signed(e[2*DW-1:DW])));
                    check("sb_q", int'(out_q), int'($signed(e[DW-1:0])));
                    check("sb_last", int'(out_tlast), int'(e[2*DW]));
                end
            end
            hold_chk = out_tvalid && !out_tready && !clear;
            hold_val = {out_tlast, out_i, out_q};
            if (clear) begin
                model_reset();
            end else if (in_tvalid && in_tready) begin
                model_accept(int'(in_i), int'(in_q), in_tlast);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit l, input int i, input int q);
        in_tvalid = v;
        in_tlast  = l;
        in_i      = DW'(i);
        in_q      = DW'(q);
    endtask

    task automatic send(input int i, input int q, input bit l);
        drive(1'b1, l, i, q);
        step();
        drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic check_out(input string name, input int v, input int i, input int q, input int l);
        check({name, "_valid"}, int'(out_tvalid), v);
        if (v != 0) begin
            check({name, "_i"}, int'(out_i), i);
            check({name, "_q"}, int'(out_q), q);
            check({name, "_last"}, int'(out_tlast), l);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]    k;
        logic [PW-1:0] pl;
        bit            vld;
        bit            last;
        int            i;
        int            q;
        bit            e_vld;
        bit            e_last;
        int            e_i;
        int            e_q;
    } vec_t;

    vec_t vecs[$];
    bit   avg_en;

    initial begin
        vec_t v;
`ifdef IQ_DECIM_AVG_EN
        avg_en = 1'b1;
`else
        avg_en = 1'b0;
`endif
        reset_n    = 1'b0;
        clear      = 1'b0;
        decim_log2 = '0;
        pkt_len    = '0;
        out_tready = 1'b1;
        drive(1'b0, 1'b0, 0, 0);
        repeat (3) step();
        check_out("reset", 0, 0, 0, 0);
        check("reset_i", int'(out_i), 0);
        check("reset_q", int'(out_q), 0);
        check("reset_last", int'(out_tlast), 0);
        check("reset_ready", int'(in_tready), 1);
        reset_n = 1'b1;
        step();

        // k=0 pass-through, ramp 1..8, packets of 4.
        for (int t = 0; t < 8; t++) begin
            v = '{k: 3'd0, pl: 16'd4, vld: 1'b1, last: 1'b0, i: t + 1, q: -(t + 1),
                  e_vld: 1'b1, e_last: (t == 3 || t == 7), e_i: t + 1, e_q: -(t + 1)};
            vecs.push_back(v);
        end
        v = '{k: 3'd0, pl: 16'd4, vld: 1'b0, last: 1'b0, i: 0, q: 0,
              e_vld: 1'b0, e_last: 1'b0, e_i: 0, e_q: 0};
        vecs.push_back(v);
        // k=2, no packet length, ramp 0..15 with burst end on 15.
        for (int t = 0; t < 16; t++) begin
            v = '{k: 3'd2, pl: 16'd0, vld: 1'b1, last: (t == 15), i: t, q: -t,
                  e_vld: (t % 4 == 3), e_last: (t == 15),
                  e_i: avg_en ? (t / 4) * 4 + 1 : t,
                  e_q: avg_en ? -((t / 4) * 4 + 2) : -t};
            vecs.push_back(v);
        end
        v = '{k: 3'd2, pl: 16'd0, vld: 1'b0, last: 1'b0, i: 0, q: 0,
              e_vld: 1'b0, e_last: 1'b0, e_i: 0, e_q: 0};
        vecs.push_back(v);

        foreach (vecs[n]) begin
            decim_log2 = vecs[n].k;
            pkt_len    = vecs[n].pl;
            drive(vecs[n].vld, vecs[n].last, vecs[n].i, vecs[n].q);
            step();
            check_out($sformatf("vec%0d", n), int'(vecs[n].e_vld), vecs[n].e_i,
                      vecs[n].e_q, int'(vecs[n].e_last));
        end
        drive(1'b0, 1'b0, 0, 0);

        // Averaging rounding: 1,2,3,5 / -1,-2,-3,-5 with k=2.
        decim_log2 = 3'd2;
        pkt_len    = '0;
        send(1, -1, 1'b0);
        send(2, -2, 1'b0);
        send(3, -3, 1'b0);
        send(5, -5, 1'b0);
        check_out("avg_round", 1, avg_en ? 2 : 5, avg_en ? -3 : -5, 0);
        step();

        // Partial group closed by tlast, then phase restarts at 0; a mid-group
        // change of k must be ignored until the 8-sample group completes.
        decim_log2 = 3'd3;
        send(10, -10, 1'b0);
        send(20, -20, 1'b0);
        send(30, -30, 1'b1);
        check_out("partial", 1, avg_en ? 7 : 30, avg_en ? -8 : -30, 1);
        for (int t = 1; t <= 8; t++) begin
            if (t == 3) decim_log2 = 3'd1;
            send(t, -t, 1'b0);
            if (t < 8) check_out($sformatf("regroup%0d", t), 0, 0, 0, 0);
        end
        check_out("regroup", 1, avg_en ? 4 : 8, avg_en ? -5 : -8, 0);
        step();

        // Randomized: k=1 with 1010 tready, then random k (incl. saturation).
        decim_log2 = 3'd1;
        pkt_len    = 16'd3;
        for (int c = 0; c < 500; c++) begin
            out_tready = (c % 2 == 0);
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
            step();
        end
        pkt_len = 16'd5;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) == 0) decim_log2 = 3'($urandom_range(0, 7));
            out_tready = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                  int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
            step();
        end
        drive(1'b0, 1'b0, 0, 0);
        out_tready = 1'b1;
        for (int c = 0; c < 20 && (exp_q.size() != 0 || out_tvalid); c++) step();
        check("drain_empty", exp_q.size(), 0);

        // Async reset in the middle of a group.
        decim_log2 = 3'd2;
        pkt_len    = '0;
        send(1, -1, 1'b0);
        send(2, -2, 1'b0);
        send(3, -3, 1'b0);
        reset_n = 1'b0;
        #1;
        check("rst_async_valid", int'(out_tvalid), 0);
        check("rst_async_i", int'(out_i), 0);
        check("rst_async_q", int'(out_q), 0);
        check("rst_async_last", int'(out_tlast), 0);
        step();
        step();
        reset_n = 1'b1;
        step();
        decim_log2 = 3'd2;
        for (int t = 0; t < 3; t++) send(4, -4, 1'b0);
        check_out("post_rst_mid", 0, 0, 0, 0);
        send(4, -4, 1'b0);
        check_out("post_rst", 1, 4, -4, 0);
        step();

        // Clear with a stalled output, then clear against a same-cycle input.
        decim_log2 = 3'd0;
        out_tready = 1'b0;
        send(9, -9, 1'b0);
        check_out("stall_load", 1, 9, -9, 0);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_valid", int'(out_tvalid), 0);
        check("clear_i", int'(out_i), 0);
        out_tready = 1'b1;
        clear = 1'b1;
        drive(1'b1, 1'b0, 55, -55);
        step();
        clear = 1'b0;
        drive(1'b0, 1'b0, 0, 0);
        check("clear_wins_valid", int'(out_tvalid), 0);
        decim_log2 = 3'd2;
        for (int t = 0; t < 3; t++) send(4, -4, 1'b0);
        check_out("post_clr_mid", 0, 0, 0, 0);
        send(4, -4, 1'b0);
        check_out("post_clr", 1, 4, -4, 0);
        step();
        step();
        check("final_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so a stuck run still ends with a report.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit reached");
    end

endmodule
